ysyx_25070198_mem_arbiter: RTL and testbench

YSYX_25070198_MEM_ARBITER -- requirements
Module: ysyx_25070198_mem_arbiter

---
 rtl/ysyx_25070198_mem_arbiter.sv | 100 ++++++++++
 tb/tb_ysyx_25070198_mem_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25070198_mem_arbiter.sv
// ysyx_25070198_mem_arbiter: single-outstanding IFU/LSU arbiter onto one memory port, with response timeout.
// Optional macro ARBITER_RR_EN selects round-robin arbitration; otherwise LSU has fixed priority over IFU.
module ysyx_25070198_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_reqValid,
    input  logic [31:0] ifu_raddr,
    output logic        ifu_reqReady,
    output logic        ifu_respValid,
    output logic [31:0] ifu_rdata,
    output logic        ifu_respErr,
    input  logic        lsu_reqValid,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_reqReady,
    output logic        lsu_respValid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_respErr,
    output logic        mem_reqValid,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_reqReady,
    input  logic        mem_respValid,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    localparam logic [7:0] TO = 8'(TIMEOUT_CYC);
    state_t      state_q;
    logic [31:0] addr_q, wdata_q;
    logic        wen_q, gnt_q;
    logic [3:0]  wmask_q;
    logic [7:0]  cnt_q, cnt_d;
    logic        gnt_lsu, any_req, busy, timeout, resp_fire, err_fire, done;
`ifdef ARBITER_RR_EN
    logic rr_q;
    assign gnt_lsu = lsu_reqValid & (~ifu_reqValid | ~rr_q);
`else
    assign gnt_lsu = lsu_reqValid;
`endif
    assign any_req   = lsu_reqValid | ifu_reqValid;
    assign busy      = state_q != IDLE;
    assign cnt_d     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign timeout   = busy & (cnt_q == TO);
    assign resp_fire = (state_q == RESP) & mem_respValid;
    assign err_fire  = timeout & ~resp_fire;
    assign done      = resp_fire | err_fire;

    assign lsu_reqReady  = ~rst & (state_q == IDLE) & gnt_lsu;
    assign ifu_reqReady  = ~rst & (state_q == IDLE) & ifu_reqValid & ~gnt_lsu;
    assign lsu_respValid = done & gnt_q;
    assign ifu_respValid = done & ~gnt_q;
    assign lsu_respErr   = err_fire & gnt_q;
    assign ifu_respErr   = err_fire & ~gnt_q;
    assign lsu_rdata     = (resp_fire & gnt_q) ? mem_rdata : 32'h0;
    assign ifu_rdata     = (resp_fire & ~gnt_q) ? mem_rdata : 32'h0;
    assign mem_reqValid  = (state_q == REQ) & ~timeout;
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

    // Transaction FSM: grant and latch in IDLE, issue in REQ, wait for data or timeout in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wen_q   <= 1'b0;
            wmask_q <= 4'h0;
            gnt_q   <= 1'b0;
            cnt_q   <= 8'h0;
`ifdef ARBITER_RR_EN
            rr_q    <= 1'b0;
`endif
        end else if (state_q == IDLE) begin
            if (any_req) begin
                state_q <= REQ;
                gnt_q   <= gnt_lsu;
                cnt_q   <= 8'h0;
                addr_q  <= gnt_lsu ? lsu_addr : ifu_raddr;
                wen_q   <= gnt_lsu & lsu_wen;
                wdata_q <= gnt_lsu ? lsu_wdata : 32'h0;
                wmask_q <= gnt_lsu ? lsu_wmask : 4'hF;
`ifdef ARBITER_RR_EN
                rr_q    <= gnt_lsu;
`endif
            end
        end else begin
            cnt_q <= cnt_d;
            if (done) state_q <= IDLE;
            else if (state_q == REQ && mem_reqReady) state_q <= RESP;
        end
    end
endmodule

// File: tb/tb_ysyx_25070198_mem_arbiter.sv
// tb_ysyx_25070198_mem_arbiter: directed self-checking bench for the memory arbiter.
module tb_ysyx_25070198_mem_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        ifu_reqValid = 1'b0;
    logic [31:0] ifu_raddr = 32'h0;
    logic        ifu_reqReady, ifu_respValid, ifu_respErr;
    logic [31:0] ifu_rdata;
    logic        lsu_reqValid = 1'b0, lsu_wen = 1'b0;
    logic [31:0] lsu_addr = 32'h0, lsu_wdata = 32'h0;
    logic [3:0]  lsu_wmask = 4'h0;
    logic        lsu_reqReady, lsu_respValid, lsu_respErr;
    logic [31:0] lsu_rdata;
    logic        mem_reqValid, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_reqReady = 1'b0, mem_respValid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    int n_chk = 0, n_err = 0;

    ysyx_25070198_mem_arbiter #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_reqValid(ifu_reqValid), .ifu_raddr(ifu_raddr), .ifu_reqReady(ifu_reqReady),
        .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata), .ifu_respErr(ifu_respErr),
        .lsu_reqValid(lsu_reqValid), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_reqReady(lsu_reqReady),
        .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata), .lsu_respErr(lsu_respErr),
        .mem_reqValid(mem_reqValid), .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_reqReady(mem_reqReady),
        .mem_respValid(mem_respValid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset: outputs zero even with a request present
        #2 ifu_reqValid = 1'b1; lsu_reqValid = 1'b1;
        #1;
        chk("rst_ifu_ready", ifu_reqReady, 0);
        chk("rst_lsu_ready", lsu_reqReady, 0);
        chk("rst_mem_valid", mem_reqValid, 0);
        chk("rst_ifu_resp", ifu_respValid, 0);
        ifu_reqValid = 1'b0; lsu_reqValid = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        chk("idle_ready", {ifu_reqReady, lsu_reqReady}, 0);

        // IFU-only read, minimum latency
        ifu_reqValid = 1'b1; ifu_raddr = 32'h8000_0000;
        #1;
        chk("t1_ifu_ready", ifu_reqReady, 1);
        chk("t1_lsu_ready", lsu_reqReady, 0);
        step();
        ifu_reqValid = 1'b0; mem_reqReady = 1'b1;
        #1;
        chk("t1_mem_valid", mem_reqValid, 1);
        chk("t1_mem_addr", mem_addr, 32'h8000_0000);
        chk("t1_mem_wen", mem_wen, 0);
        chk("t1_mem_wmask", mem_wmask, 4'hF);
        chk("t1_mem_wdata", mem_wdata, 0);
        chk("t1_no_resp_c1", ifu_respValid, 0);
        step();
        mem_reqReady = 1'b0; mem_respValid = 1'b1; mem_rdata = 32'h0010_0073;
        ifu_reqValid = 1'b1;
        #1;
        chk("t1_resp", ifu_respValid, 1);
        chk("t1_rdata", ifu_rdata, 32'h0010_0073);
        chk("t1_err", ifu_respErr, 0);
        chk("t1_lsu_resp", lsu_respValid, 0);
        chk("t1_lsu_rdata", lsu_rdata, 0);
        chk("t1_no_accept_on_resp", ifu_reqReady, 0);
        chk("t1_mem_valid_resp", mem_reqValid, 0);
        ifu_reqValid = 1'b0;
        step();
        mem_respValid = 1'b0;

        // simultaneous IFU read and LSU write: LSU first, IFU afterwards
        ifu_reqValid = 1'b1; ifu_raddr = 32'h8000_0040;
        lsu_reqValid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_1000;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'h3;
        #1;
        chk("t2_lsu_ready", lsu_reqReady, 1);
        chk("t2_ifu_ready", ifu_reqReady, 0);
        step();
        lsu_reqValid = 1'b0; mem_reqReady = 1'b1;
        #1;
        chk("t2_mem_addr", mem_addr, 32'h8000_1000);
        chk("t2_mem_wen", mem_wen, 1);
        chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t2_mem_wmask", mem_wmask, 4'h3);
        chk("t2_ifu_wait", ifu_reqReady, 0);
        step();
        mem_reqReady = 1'b0; mem_respValid = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        chk("t2_lsu_resp", lsu_respValid, 1);
        chk("t2_ifu_resp", ifu_respValid, 0);
        chk("t2_ifu_rdata", ifu_rdata, 0);
        step();
        mem_respValid = 1'b0;
        #1;
        chk("t2_ifu_ready", ifu_reqReady, 1);
        step();
        ifu_reqValid = 1'b0; mem_reqReady = 1'b1;
        #1;
        chk("t2_ifu_addr", mem_addr, 32'h8000_0040);
        chk("t2_ifu_wen", mem_wen, 0);
        chk("t2_ifu_wmask", mem_wmask, 4'hF);
        step();
        mem_reqReady = 1'b0; mem_respValid = 1'b1; mem_rdata = 32'hCAFE_0001;
        #1;
        chk("t2_ifu_resp2", ifu_respValid, 1);
        chk("t2_ifu_rdata2", ifu_rdata, 32'hCAFE_0001);
        step();
        mem_respValid = 1'b0;

        // both masters requesting continuously for 6 transactions
        ifu_reqValid = 1'b1; lsu_reqValid = 1'b1; lsu_wen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            logic exp_lsu;
`ifdef ARBITER_RR_EN
            exp_lsu = (i % 2) == 0;
`else
            exp_lsu = 1'b1;
`endif
            #1;
            chk($sformatf("t3_lsu_gnt%0d", i), lsu_reqReady, exp_lsu);
            chk($sformatf("t3_ifu_gnt%0d", i), ifu_reqReady, !exp_lsu);
            step();
            mem_reqReady = 1'b1;
            step();
            mem_reqReady = 1'b0; mem_respValid = 1'b1; mem_rdata = 32'h100 + i;
            #1;
            chk($sformatf("t3_resp%0d", i), {lsu_respValid, ifu_respValid}, {exp_lsu, !exp_lsu});
            step();
            mem_respValid = 1'b0;
        end
        ifu_reqValid = 1'b0; lsu_reqValid = 1'b0;
        step();

        // timeout: memory accepts but never responds
        lsu_reqValid = 1'b1; lsu_addr = 32'h8000_2000;
        #1;
        chk("t4_lsu_ready", lsu_reqReady, 1);
        step();
        lsu_reqValid = 1'b0; mem_reqReady = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            #1;
            chk($sformatf("t4_quiet_c%0d", c), lsu_respValid, 0);
            step();
            mem_reqReady = 1'b0;
        end
        chk("t4_to_resp", lsu_respValid, 1);
        chk("t4_to_err", lsu_respErr, 1);
        chk("t4_to_rdata", lsu_rdata, 0);
        chk("t4_to_memvalid", mem_reqValid, 0);
        chk("t4_to_ifu", ifu_respValid, 0);
        step();
        mem_respValid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        #1;
        chk("t4_stray_lsu", lsu_respValid, 0);
        chk("t4_stray_ifu", ifu_respValid, 0);
        step();
        chk("t4_stray_lsu2", lsu_respValid, 0);
        mem_respValid = 1'b0;
        step();

        // timeout and response in the same cycle: normal response wins
        ifu_reqValid = 1'b1; ifu_raddr = 32'h8000_3000;
        step();
        ifu_reqValid = 1'b0; mem_reqReady = 1'b1;
        step();
        mem_reqReady = 1'b0;
        step(); step(); step();
        mem_respValid = 1'b1; mem_rdata = 32'h5555_AAAA;
        #1;
        chk("t5_resp", ifu_respValid, 1);
        chk("t5_err", ifu_respErr, 0);
        chk("t5_rdata", ifu_rdata, 32'h5555_AAAA);
        step();
        mem_respValid = 1'b0;

        // reset while in RESP abandons the transaction
        ifu_reqValid = 1'b1; ifu_raddr = 32'h8000_4000;
        step();
        ifu_reqValid = 1'b0; mem_reqReady = 1'b1;
        step();
        mem_reqReady = 1'b0;
        #2 rst = 1'b1; mem_respValid = 1'b1; mem_rdata = 32'h7777_7777;
        #1;
        chk("t6_rst_resp", ifu_respValid, 0);
        chk("t6_rst_rdata", ifu_rdata, 0);
        chk("t6_rst_memvalid", mem_reqValid, 0);
        chk("t6_rst_addr", mem_addr, 0);
        step();
        rst = 1'b0; mem_respValid = 1'b0;
        #1;
        chk("t6_post_rst_resp", ifu_respValid, 0);
        ifu_reqValid = 1'b1; ifu_raddr = 32'h8000_5000;
        #1;
        chk("t6_new_ready", ifu_reqReady, 1);
        step();
        ifu_reqValid = 1'b0; mem_reqReady = 1'b1;
        #1;
        chk("t6_new_addr", mem_addr, 32'h8000_5000);
        step();
        mem_reqReady = 1'b0; mem_respValid = 1'b1; mem_rdata = 32'h0000_0013;
        #1;
        chk("t6_new_resp", ifu_respValid, 1);
        chk("t6_new_rdata", ifu_rdata, 32'h0000_0013);
        chk("t6_new_err", ifu_respErr, 0);
        step();
        mem_respValid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
